// File: rtl/shift_reg_univ_rst_en.sv
// Universal shift register with clock enable and an autonomous burst-shift engine.
// Define SHREG_PARITY_EN to add a registered parity output tracking Q.
module shift_reg_univ_rst_en #(
  parameter int                 WIDTH   = 8,
  parameter int                 CNT_W   = 4,
  parameter logic [WIDTH-1:0]   RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] D,
  input  logic             sin_l,
  input  logic             sin_r,
  input  logic             start,
  input  logic [CNT_W-1:0] cnt,
  output logic [WIDTH-1:0] Q,
  output logic             sout_l,
  output logic             sout_r,
  output logic             busy,
  output logic             done
`ifdef SHREG_PARITY_EN
  ,
  output logic             parity
`endif
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] FIN  = 2'd2;

  logic [1:0]       state, state_next;
  logic [CNT_W-1:0] count, count_next;
  logic [2:0]       lmode, lmode_next;
  logic [WIDTH-1:0] q_next;

  function automatic logic [WIDTH-1:0] apply_op(
    input logic [2:0]       m,
    input logic [WIDTH-1:0] q,
    input logic [WIDTH-1:0] d,
    input logic             sl,
    input logic             sr
  );
    case (m)
      3'b001:  apply_op = d;
      3'b010:  apply_op = {q[WIDTH-2:0], sl};
      3'b011:  apply_op = {sr, q[WIDTH-1:1]};
      3'b100:  apply_op = {q[WIDTH-2:0], q[WIDTH-1]};
      3'b101:  apply_op = {q[0], q[WIDTH-1:1]};
      3'b110:  apply_op = '0;
      default: apply_op = q;
    endcase
  endfunction

  // FIN still has busy low, so a single-step mode presented there executes normally.
  always_comb begin
    q_next     = Q;
    state_next = state;
    count_next = count;
    lmode_next = lmode;
    if (en) begin
      case (state)
        IDLE: begin
          if (start && (mode inside {3'b010, 3'b011, 3'b100, 3'b101})) begin
            lmode_next = mode;
            count_next = cnt;
            state_next = (cnt != '0) ? RUN : FIN;
          end else begin
            q_next = apply_op(mode, Q, D, sin_l, sin_r);
          end
        end
        RUN: begin
          q_next     = apply_op(lmode, Q, D, sin_l, sin_r);
          count_next = count - CNT_W'(1);
          if (count == CNT_W'(1)) state_next = FIN;
        end
        FIN: begin
          q_next     = apply_op(mode, Q, D, sin_l, sin_r);
          state_next = IDLE;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      Q     <= RST_VAL;
      state <= IDLE;
      count <= '0;
      lmode <= 3'b000;
    end else begin
      Q     <= q_next;
      state <= state_next;
      count <= count_next;
      lmode <= lmode_next;
    end
  end

`ifdef SHREG_PARITY_EN
  // q_next equals Q while disabled, so parity holds without a separate enable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) parity <= ^RST_VAL;
    else     parity <= ^q_next;
  end
`endif

  assign sout_l = Q[WIDTH-1];
  assign sout_r = Q[0];
  assign busy   = (state == RUN);
  assign done   = (state == FIN) && en;

endmodule

// File: tb/tb_shift_reg_univ_rst_en.sv
// Self-checking bench for shift_reg_univ_rst_en: directed vector table, corner sequences
// and randomized traffic against an arithmetic reference model.
module tb_shift_reg_univ_rst_en;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [2:0] mode;
  logic [7:0] D;
  logic       sin_l;
  logic       sin_r;
  logic       start;
  logic [3:0] cnt;
  logic [7:0] Q;
  logic       sout_l;
  logic       sout_r;
  logic       busy;
  logic       done;
`ifdef SHREG_PARITY_EN
  logic       parity;
`endif

  int errors = 0;
  int checks = 0;

  // Reference model: plain integer register value, shifts still owed, and a pending done.
  int         mq;
  int         left;
  bit         fin;
  logic [2:0] lm;

  typedef struct {
    bit         en;
    logic [2:0] mode;
    logic [7:0] d;
    bit         sl;
    bit         sr;
    bit         start;
    logic [3:0] cnt;
    logic [7:0] q;
    bit         busy;
    bit         done;
  } vec_t;

  vec_t tbl[25];

  shift_reg_univ_rst_en #(.WIDTH(8), .CNT_W(4), .RST_VAL(8'h00)) dut (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .mode   (mode),
    .D      (D),
    .sin_l  (sin_l),
    .sin_r  (sin_r),
    .start  (start),
    .cnt    (cnt),
    .Q      (Q),
    .sout_l (sout_l),
    .sout_r (sout_r),
    .busy   (busy),
    .done   (done)
`ifdef SHREG_PARITY_EN
    ,
    .parity (parity)
`endif
  );

  always #5 clk = ~clk;

  function automatic vec_t vec(bit e, logic [2:0] m, logic [7:0] d, bit sl, bit sr, bit st,
                               logic [3:0] c, logic [7:0] q, bit b, bit dn);
    vec_t v;
    v.en = e; v.mode = m; v.d = d; v.sl = sl; v.sr = sr; v.start = st; v.cnt = c;
    v.q = q; v.busy = b; v.done = dn;
    return v;
  endfunction

  function automatic int modelOp(logic [2:0] m, int q, int d, bit sl, bit sr);
    case (m)
      3'd1:    return d;
      3'd2:    return (q * 2 + int'(sl)) % 256;
      3'd3:    return q / 2 + (sr ? 128 : 0);
      3'd4:    return (q * 2) % 256 + q / 128;
      3'd5:    return q / 2 + (q % 2) * 128;
      3'd6:    return 0;
      default: return q;
    endcase
  endfunction

  task automatic modelStep(bit e, logic [2:0] m, logic [7:0] dd, bit sl, bit sr, bit st,
                           logic [3:0] c);
    if (!e) return;
    if (left > 0) begin
      mq = modelOp(lm, mq, int'(dd), sl, sr);
      left--;
      if (left == 0) fin = 1'b1;
    end else if (fin) begin
      fin = 1'b0;
      mq  = modelOp(m, mq, int'(dd), sl, sr);
    end else if (st && m >= 3'd2 && m <= 3'd5) begin
      lm   = m;
      left = int'(c);
      if (left == 0) fin = 1'b1;
    end else begin
      mq = modelOp(m, mq, int'(dd), sl, sr);
    end
  endtask

  task automatic modelReset();
    mq = 0; left = 0; fin = 1'b0; lm = 3'b000;
  endtask

  task automatic checkVal(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic checkOutput(string tag);
    checkVal({tag, ".Q"},      int'(Q),      mq);
    checkVal({tag, ".busy"},   int'(busy),   (left > 0) ? 1 : 0);
    checkVal({tag, ".done"},   int'(done),   (fin && en) ? 1 : 0);
    checkVal({tag, ".sout_l"}, int'(sout_l), mq / 128);
    checkVal({tag, ".sout_r"}, int'(sout_r), mq % 2);
`ifdef SHREG_PARITY_EN
    checkVal({tag, ".parity"}, int'(parity), $countones(mq) % 2);
`endif
  endtask

  // Inputs change 1 time unit after a rising edge; outputs are sampled at the same point.
  task automatic applyStimulus(bit e, logic [2:0] m, logic [7:0] dd, bit sl, bit sr, bit st,
                               logic [3:0] c);
    en = e; mode = m; D = dd; sin_l = sl; sin_r = sr; start = st; cnt = c;
    modelStep(e, m, dd, sl, sr, st, c);
    @(posedge clk);
    #1;
  endtask

  task automatic pulseReset(string tag);
    #2 rst = 1'b1;
    modelReset();
    #1 checkOutput(tag);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; mode = 3'b000; D = 8'h00;
    sin_l = 1'b0; sin_r = 1'b0; start = 1'b0; cnt = 4'd0;
    modelReset();

    tbl[0]  = vec(1, 3'b001, 8'h81, 0, 0, 0, 4'd0, 8'h81, 0, 0);
    tbl[1]  = vec(1, 3'b100, 8'h00, 0, 0, 0, 4'd0, 8'h03, 0, 0);
    tbl[2]  = vec(1, 3'b101, 8'h00, 0, 0, 0, 4'd0, 8'h81, 0, 0);
    tbl[3]  = vec(1, 3'b101, 8'h00, 0, 0, 0, 4'd0, 8'hC0, 0, 0);
    tbl[4]  = vec(1, 3'b001, 8'h3C, 0, 0, 0, 4'd0, 8'h3C, 0, 0);
    tbl[5]  = vec(0, 3'b010, 8'h00, 1, 0, 0, 4'd0, 8'h3C, 0, 0);
    tbl[6]  = vec(0, 3'b010, 8'h00, 1, 0, 0, 4'd0, 8'h3C, 0, 0);
    tbl[7]  = vec(0, 3'b010, 8'h00, 1, 0, 0, 4'd0, 8'h3C, 0, 0);
    tbl[8]  = vec(1, 3'b010, 8'h00, 1, 0, 0, 4'd0, 8'h79, 0, 0);
    tbl[9]  = vec(1, 3'b001, 8'hF0, 0, 0, 0, 4'd0, 8'hF0, 0, 0);
    tbl[10] = vec(1, 3'b011, 8'h00, 0, 0, 1, 4'd4, 8'hF0, 1, 0);
    tbl[11] = vec(1, 3'b001, 8'hFF, 0, 0, 1, 4'd9, 8'h78, 1, 0);
    tbl[12] = vec(1, 3'b110, 8'h00, 0, 0, 0, 4'd0, 8'h3C, 1, 0);
    tbl[13] = vec(1, 3'b001, 8'hAA, 0, 0, 0, 4'd0, 8'h1E, 1, 0);
    tbl[14] = vec(1, 3'b000, 8'h00, 0, 0, 0, 4'd0, 8'h0F, 0, 1);
    tbl[15] = vec(1, 3'b000, 8'h00, 0, 0, 0, 4'd0, 8'h0F, 0, 0);
    tbl[16] = vec(1, 3'b010, 8'h00, 0, 0, 1, 4'd0, 8'h0F, 0, 1);
    tbl[17] = vec(1, 3'b000, 8'h00, 0, 0, 0, 4'd0, 8'h0F, 0, 0);
    tbl[18] = vec(1, 3'b001, 8'h5A, 0, 0, 1, 4'd3, 8'h5A, 0, 0);
    tbl[19] = vec(1, 3'b000, 8'h00, 0, 0, 0, 4'd0, 8'h5A, 0, 0);
    tbl[20] = vec(1, 3'b010, 8'h00, 1, 0, 1, 4'd2, 8'h5A, 1, 0);
    tbl[21] = vec(0, 3'b000, 8'h00, 1, 0, 0, 4'd0, 8'h5A, 1, 0);
    tbl[22] = vec(0, 3'b000, 8'h00, 1, 0, 0, 4'd0, 8'h5A, 1, 0);
    tbl[23] = vec(1, 3'b000, 8'h00, 1, 0, 0, 4'd0, 8'hB5, 1, 0);
    tbl[24] = vec(1, 3'b000, 8'h00, 0, 0, 0, 4'd0, 8'h6A, 0, 1);

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    checkOutput("reset");
    checkVal("reset.Q_const", int'(Q), 'h00);

    for (int i = 0; i < 25; i++) begin
      applyStimulus(tbl[i].en, tbl[i].mode, tbl[i].d, tbl[i].sl, tbl[i].sr, tbl[i].start,
                    tbl[i].cnt);
      checkVal($sformatf("vec%0d.Q", i),    int'(Q),    int'(tbl[i].q));
      checkVal($sformatf("vec%0d.busy", i), int'(busy), int'(tbl[i].busy));
      checkVal($sformatf("vec%0d.done", i), int'(done), int'(tbl[i].done));
      checkOutput($sformatf("vec%0d.model", i));
    end

    // done is masked while disabled in FIN and reappears as soon as en returns.
    applyStimulus(0, 3'b000, 8'h00, 0, 0, 0, 4'd0);
    checkVal("fin_en0.done", int'(done), 0);
    en = 1'b1;
    #1 checkVal("fin_en1.done", int'(done), 1);
    checkOutput("fin_en1");
    applyStimulus(1, 3'b000, 8'h00, 0, 0, 0, 4'd0);
    checkOutput("fin_exit");

    // Asynchronous reset between edges.
    applyStimulus(1, 3'b001, 8'hA5, 0, 0, 0, 4'd0);
    checkVal("load_a5.Q", int'(Q), 'hA5);
    pulseReset("async_rst");
    checkVal("async_rst.Q_const", int'(Q), 'h00);

    // Reset in the middle of a shl burst, then a complete fresh burst.
    applyStimulus(1, 3'b010, 8'h00, 1, 0, 1, 4'd8);
    checkOutput("mid_start");
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 3'b000, 8'h00, 1, 0, 0, 4'd0);
      checkOutput("mid_shift");
    end
    checkVal("mid_shift3.Q", int'(Q), 'h07);
    pulseReset("mid_rst");
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 3'b000, 8'h00, 1, 0, 0, 4'd0);
      checkVal("mid_rst_nodone", int'(done), 0);
      checkOutput("mid_rst_after");
    end
    applyStimulus(1, 3'b010, 8'h00, 1, 0, 1, 4'd8);
    checkOutput("fresh_start");
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1, 3'b001, 8'h00, 1, 0, 1, 4'd3);
      checkVal("fresh_busy", int'(busy), (i < 7) ? 1 : 0);
      checkOutput("fresh_run");
    end
    checkVal("fresh_end.Q", int'(Q), 'hFF);
    checkVal("fresh_end.done", int'(done), 1);

    // Randomized traffic against the reference model.
    for (int i = 0; i < 400; i++) begin
      applyStimulus($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)), 8'($urandom),
                    1'($urandom), 1'($urandom), $urandom_range(0, 2) == 0,
                    4'($urandom_range(0, 15)));
      checkOutput("rand");
      if ($urandom_range(0, 59) == 0) pulseReset("rand_rst");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/shift_reg_univ_rst_en.md
Name: shift_reg_univ_rst_en

Overview:
- Parametrised successor of the single-bit D flip-flop with reset and enable.
- WIDTH-bit universal register: hold, parallel load, shift left/right, rotate left/right, synchronous clear.
- Adds a burst engine that performs a programmed number of shifts autonomously, with busy/done status.
- Used as a datapath register and as a serializer/deserializer front end.

Parameters:
- WIDTH, 8, register width in bits (>= 2)
- CNT_W, 4, width of the burst count input; max burst = 2^CNT_W - 1 shifts
- RST_VAL, 0, value loaded into Q on rst (WIDTH bits)

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  reset; one clock; asynchronous, active-high
- en  input  1  clock enable; when 0, the register and the burst engine hold state
- mode  input  3  operation select (encoding below)
- D  input  WIDTH  parallel load data
- sin_l  input  1  serial in, enters at bit 0 on a shift left
- sin_r  input  1  serial in, enters at bit WIDTH-1 on a shift right
- start  input  1  request a burst, using the current mode and cnt
- cnt  input  CNT_W  number of shifts in the burst
- Q  output  WIDTH  register contents
- sout_l  output  1  Q[WIDTH-1], combinational
- sout_r  output  1  Q[0], combinational
- busy  output  1  burst in progress
- done  output  1  one-cycle pulse at burst completion

Behaviour:
- Reset (async, rst=1):
  - Q=RST_VAL, busy=0, done=0, internal count=0, latched mode=000.
  - Overrides everything, including mid-burst; the burst is abandoned with no done pulse.
- Mode encoding (applies on a rising edge with en=1 and busy=0):
  - 000 hold
  - 001 load: Q<=D
  - 010 shl: Q<={Q[W-2:0],sin_l}
  - 011 shr: Q<={sin_r,Q[W-1:1]}
  - 100 rotl: Q<={Q[W-2:0],Q[W-1]}
  - 101 rotr: Q<={Q[0],Q[W-1:1]}
  - 110 clear: Q<=0
  - 111 hold (reserved)
- Latency: one clock from input to Q. sout_l/sout_r follow Q combinationally.
- en=0:
  - Q, busy, count and latched mode all hold.
  - done is forced to 0 and is not issued until en returns.
- Burst FSM states: IDLE, RUN, FIN.
  - IDLE: on an edge with en=1, start=1, mode in {010,011,100,101}: latch mode and cnt.
    - cnt!=0 -> RUN, busy=1 from the next cycle.
    - cnt==0 -> FIN.
    - Q is not modified on the start edge; the mode is not also executed as a single op.
  - IDLE, start=1 with a non-shift mode: start ignored, the mode executes normally.
  - RUN: each en=1 edge performs one shift of the latched mode and decrements count.
    - The edge that takes count from 1 to 0 performs the last shift and moves to FIN.
    - busy=1 throughout RUN.
  - RUN inputs: mode, D, start and cnt are ignored. sin_l/sin_r are sampled live on every shift.
  - FIN: busy=0, done=1 for exactly one cycle, then IDLE on the next edge.
    - A start seen in FIN is ignored.
    - FIN advances only with en=1.
- Burst of N shifts: busy high for N cycles (with en held high); done high in cycle N+1 after the start edge.
- Count arithmetic is unsigned CNT_W bits; no wrap. The maximum cnt performs 2^CNT_W-1 shifts.
- A burst with N >= WIDTH using shl/shr fully replaces Q with serial data.

Optional Feature:
- Macro SHREG_PARITY_EN.
- Defined:
  - Extra output port parity (1 bit) = registered XOR-reduce of the next Q value, so it is valid in the same cycle as Q.
  - parity resets to ^RST_VAL and holds with en=0.
- Undefined: the parity port and its logic do not exist; all other behaviour is identical.

Test Plan (WIDTH=8, CNT_W=4, RST_VAL=0):
- Async reset: assert rst between clock edges with Q=8'hA5 -> Q=8'h00 immediately, busy=0, done=0.
- Load, then single rotate:
  - mode=001, D=8'h81, en=1 -> Q=8'h81.
  - mode=100 -> Q=8'h03.
  - mode=101 twice -> Q=8'h81 then Q=8'hC0.
- Enable gating: Q=8'h3C, mode=010, sin_l=1, en=0 for 3 edges -> Q stays 8'h3C; en=1 for 1 edge -> Q=8'h79.
- Burst shr:
  - Q=8'hF0, start=1, mode=011, cnt=4, sin_r=0.
  - busy=1 for 4 cycles; Q=8'h0F after the 4th shift; done=1 on the next cycle only.
  - D/mode changes during the burst have no effect.
- Burst edge cases:
  - cnt=0 -> no shift, busy stays 0, done pulses one cycle after start.
  - start with mode=001 -> plain load, done never asserts.
  - en=0 mid-burst for 2 cycles -> burst stretches by 2 cycles with the shift count unchanged.
- Reset mid-burst: start cnt=8 shl, assert rst after 3 shifts -> Q=8'h00, busy=0, no done pulse; a fresh start afterwards runs a full burst.
